// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares the single cache access port between four requesters (for example
// fetch, load, store and refill) using round-robin priority. It picks a winner,
// drives the one-hot grant and its binary index to the cache datapath, and
// pulses cache_start. It then waits for cache_done, or gives up after
// TIMEOUT_CYCLES cycles, and finally acks the winner or pulses timeout.
//
// Parameters
//   TIMEOUT_CYCLES  maximum number of WAIT cycles before the access is aborted
//                   (must be >= 2)
//
// Ports
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous reset, active-high
//   req          in   4  level-sensitive request lines, bit i = requester i
//   cache_done   in   1  cache finished the current access (looked at in WAIT only)
//   gnt          out  4  one-hot grant, all-zero when no grant is active
//   gnt_idx      out  2  binary index of the set gnt bit
//   cache_start  out  1  one-cycle pulse launching the access for gnt_idx
//   ack          out  4  one-hot, one-cycle completion pulse to the winner
//   timeout      out  1  one-cycle pulse: access aborted without cache_done
//   busy         out  1  high while an access is being issued or awaited
//
// Every output is either a register or a decode of the registered state, so
// there is no combinational path from req or cache_done to any output.
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       cache_done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       cache_start,
    output logic [3:0] ack,
    output logic       timeout,
    output logic       busy
);

    // The timer counts 0 .. TIMEOUT_CYCLES-1 and is reloaded in ISSUE, so it
    // never has to wrap through overflow.
    localparam int            TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [3:0]    r_gnt;
    logic [1:0]    r_gnt_idx;
    logic [3:0]    r_ack;
    logic          r_timeout;
    logic [1:0]    r_last;
    logic [TW-1:0] r_timer;

    logic          w_found;
    logic [1:0]    w_win_idx;
    logic [1:0]    w_cand;
    logic          w_expired;

    // Round-robin winner: scan last+1, last+2, last+3, last (mod 4) and take
    // the first requester that is asking. The 2-bit add wraps by itself.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = 2'd0;
        w_cand    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + k[1:0];
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    assign w_expired = (r_timer == TMAX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (cache_done || w_expired) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Grant, pointer, timer and completion pulses. ack and timeout default low
    // every cycle so that each is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= 4'd0;
            r_gnt_idx <= 2'd0;
            r_ack     <= 4'd0;
            r_timeout <= 1'b0;
            r_last    <= 2'd3;
            r_timer   <= '0;
        end else begin
            r_ack     <= 4'd0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt     <= 4'b0001 << w_win_idx;
                        r_gnt_idx <= w_win_idx;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    // done takes precedence over a simultaneous expiry
                    if (cache_done) begin
                        r_ack     <= r_gnt;
                        r_last    <= r_gnt_idx;
                        r_gnt     <= 4'd0;
                        r_gnt_idx <= 2'd0;
                    end else if (w_expired) begin
                        // pointer still advances so a stuck requester cannot starve others
                        r_timeout <= 1'b1;
                        r_last    <= r_gnt_idx;
                        r_gnt     <= 4'd0;
                        r_gnt_idx <= 2'd0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_gnt     <= 4'd0;
                    r_gnt_idx <= 2'd0;
                end
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        cache_start = (r_state == S_ISSUE);
        busy        = (r_state == S_ISSUE) || (r_state == S_WAIT);
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign ack     = r_ack;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_port_arbiter
//
// Directed bench for cache_port_arbiter followed by a random phase that
// checks the grant invariants and the round-robin fairness bound.
// -----------------------------------------------------------------------------
module tb_cache_port_arbiter;

    localparam int TC = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       cache_done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       cache_start;
    logic [3:0] ack;
    logic       timeout;
    logic       busy;

    int n_cmp;
    int n_err;

    cache_port_arbiter #(.TIMEOUT_CYCLES(TC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .cache_done (cache_done),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .cache_start(cache_start),
        .ack        (ack),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Called while the arbiter is in IDLE with req already set. Grants, waits
    // nwait cycles in WAIT, then raises done and checks the ack.
    task automatic do_access(input logic [1:0] exp_idx, input int nwait);
        logic [3:0] exp_g;
        exp_g = 4'b0001 << exp_idx;
        tick();
        chk("grant_idx", {6'd0, gnt_idx}, {6'd0, exp_idx});
        chk("grant_vec", {4'd0, gnt}, {4'd0, exp_g});
        chk("start", {7'd0, cache_start}, 8'd1);
        tick();
        chk("start_once", {7'd0, cache_start}, 8'd0);
        chk("busy_wait", {7'd0, busy}, 8'd1);
        repeat (nwait - 1) tick();
        cache_done = 1'b1;
        tick();
        cache_done = 1'b0;
        chk("ack_vec", {4'd0, ack}, {4'd0, exp_g});
        chk("ack_gnt_clr", {4'd0, gnt}, 8'd0);
        chk("ack_no_to", {7'd0, timeout}, 8'd0);
    endtask

    initial begin
        logic [3:0] r_req;
        logic       was_idle;
        logic       prev_start;
        int         cnt [4];

        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        req        = 4'd0;
        cache_done = 1'b0;

        // 1: reset then a single access from requester 0
        tick();
        tick();
        rst = 1'b0;
        chk("rst_gnt", {4'd0, gnt}, 8'd0);
        chk("rst_idx", {6'd0, gnt_idx}, 8'd0);
        chk("rst_start", {7'd0, cache_start}, 8'd0);
        chk("rst_ack", {4'd0, ack}, 8'd0);
        chk("rst_to", {7'd0, timeout}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        req = 4'b0001;
        tick();
        chk("t1_gnt", {4'd0, gnt}, 8'h01);
        chk("t1_idx", {6'd0, gnt_idx}, 8'd0);
        chk("t1_start", {7'd0, cache_start}, 8'd1);
        chk("t1_busy", {7'd0, busy}, 8'd1);
        req = 4'b0000;
        tick();
        chk("t1_start_pulse", {7'd0, cache_start}, 8'd0);
        chk("t1_gnt_hold", {4'd0, gnt}, 8'h01);
        tick();
        tick();
        cache_done = 1'b1;
        tick();
        cache_done = 1'b0;
        chk("t1_ack", {4'd0, ack}, 8'h01);
        chk("t1_gnt_clr", {4'd0, gnt}, 8'd0);
        chk("t1_busy_low", {7'd0, busy}, 8'd0);
        tick();
        chk("t1_ack_pulse", {4'd0, ack}, 8'd0);
        chk("t1_idle", {7'd0, busy}, 8'd0);

        // 2: all four requesting, fresh pointer -> 0,1,2,3,0
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        req = 4'b1111;
        do_access(2'd0, 2);
        do_access(2'd1, 2);
        do_access(2'd2, 2);
        do_access(2'd3, 2);
        do_access(2'd0, 2);

        // 3: serve idx 1, then 1010 goes to 3 before 1
        do_access(2'd1, 1);
        req = 4'b1010;
        do_access(2'd3, 1);
        do_access(2'd1, 3);

        // 4: requester 2 never completes -> timeout after TC WAIT cycles
        req = 4'b0100;
        tick();
        chk("t4_idx", {6'd0, gnt_idx}, 8'd2);
        req = 4'b0110;
        tick();
        for (int i = 0; i < TC - 1; i++) begin
            tick();
            chk("t4_no_to_yet", {7'd0, timeout}, 8'd0);
            chk("t4_busy", {7'd0, busy}, 8'd1);
        end
        tick();
        chk("t4_timeout", {7'd0, timeout}, 8'd1);
        chk("t4_no_ack", {4'd0, ack}, 8'd0);
        chk("t4_gnt_clr", {4'd0, gnt}, 8'd0);
        chk("t4_busy_low", {7'd0, busy}, 8'd0);
        tick();
        chk("t4_to_pulse", {7'd0, timeout}, 8'd0);
        chk("t4_next_idx", {6'd0, gnt_idx}, 8'd1);
        chk("t4_next_start", {7'd0, cache_start}, 8'd1);

        // 5: reset in the middle of WAIT drops the access
        tick();
        chk("t5_in_wait", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_gnt", {4'd0, gnt}, 8'd0);
        chk("t5_idx", {6'd0, gnt_idx}, 8'd0);
        chk("t5_busy", {7'd0, busy}, 8'd0);
        chk("t5_ack", {4'd0, ack}, 8'd0);
        chk("t5_to", {7'd0, timeout}, 8'd0);
        chk("t5_start", {7'd0, cache_start}, 8'd0);
        req = 4'b1001;
        do_access(2'd0, 1);
        req = 4'b1000;
        do_access(2'd3, 1);
        req = 4'b0000;
        tick();

        // 6: random requests and done, invariants and fairness each cycle
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        prev_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            req        = 4'($urandom_range(0, 15));
            cache_done = ($urandom_range(0, 3) == 0);
            r_req      = req;
            was_idle   = !busy;
            prev_start = cache_start;
            tick();
            chk("r_onehot", {7'd0, $onehot0(gnt)}, 8'd1);
            chk("r_idx_match", {6'd0, gnt_idx}, {6'd0, enc(gnt)});
            chk("r_ack_to", {7'd0, (|ack) && timeout}, 8'd0);
            chk("r_start_twice", {7'd0, cache_start && prev_start}, 8'd0);
            chk("r_ack_onehot", {7'd0, $onehot0(ack)}, 8'd1);
            if (was_idle) begin
                for (int i = 0; i < 4; i++) begin
                    if (!r_req[i] || (cache_start && gnt[i])) begin
                        cnt[i] = 0;
                    end else if (cache_start) begin
                        cnt[i]++;
                    end
                    chk("r_starve", {7'd0, cnt[i] > 3}, 8'd0);
                end
            end
        end
        cache_done = 1'b0;
        req        = 4'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
